// File: rtl/fir_pkg.sv
// Shared FIR helpers: default 16-tap lowpass half-table, clog2, output saturation.
package fir_pkg;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((32'd1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Half of a symmetric lowpass; c[i] pairs with tap TAPS-1-i.
  function automatic logic signed [7:0] coef_default(input int unsigned i);
    case (i)
      0:       return -8'sd1;
      1:       return -8'sd2;
      2:       return -8'sd3;
      3:       return -8'sd1;
      4:       return  8'sd4;
      5:       return  8'sd13;
      6:       return  8'sd23;
      7:       return  8'sd30;
      default: return  8'sd0;
    endcase
  endfunction

  function automatic logic signed [63:0] sat_max(input int unsigned ow);
    return (64'sd1 <<< (ow - 1)) - 64'sd1;
  endfunction

  // {above max, below min} of a full-precision value against an ow-bit signed range.
  function automatic logic [1:0] sat_chk(input logic signed [63:0] v, input int unsigned ow);
    logic signed [63:0] hi;
    hi = sat_max(ow);
    return {v > hi, v < (-hi - 64'sd1)};
  endfunction

endpackage

// File: rtl/fir_sym_param_if.sv
// Sample stream bus of the symmetric FIR: master feeds samples, slave returns results.
interface fir_sym_param_if #(
  parameter int DW = 8,
  parameter int OW = 20
);
  logic                 en;
  logic [DW-1:0]        xin;
  logic                 clr;
  logic                 valid;
  logic signed [OW-1:0] yout;
  logic                 sat;

  modport master (output en, xin, clr, input valid, yout, sat);
  modport slave  (input en, xin, clr, output valid, yout, sat);
endinterface

// File: rtl/fir_add_tree.sv
// Registered binary adder tree, one register level per tree level, full precision.
module fir_add_tree
  import fir_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 18
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          clr,
  input  logic                          vin,
  input  logic signed [W-1:0]           leaf [N],
  output logic                          vout,
  output logic signed [W+clog2(N)-1:0]  sum
);
  localparam int L  = clog2(N);
  localparam int NP = 1 << L;
  localparam int SW = W + L;

  logic signed [SW-1:0] lf  [NP];
  logic signed [SW-1:0] src [L][NP];
  logic signed [SW-1:0] st  [L][NP/2];
  logic [L-1:0]         vt;
  logic [L:0]           vc;

  for (genvar i = 0; i < NP; i++) begin : g_leaf
    if (i < N) begin : g_used
      assign lf[i] = SW'(leaf[i]);
    end else begin : g_pad
      assign lf[i] = '0;
    end
  end

  // Level l reads row l of src; rows are zero-padded so every level adds NP/2 pairs.
  always_comb begin
    for (int unsigned l = 0; l < L; l++)
      for (int unsigned i = 0; i < NP; i++)
        src[l][i] = '0;
    for (int unsigned i = 0; i < NP; i++)
      src[0][i] = lf[i];
    for (int unsigned l = 1; l < L; l++)
      for (int unsigned i = 0; i < NP/2; i++)
        src[l][i] = st[l-1][i];
  end

  assign vc = {vt, vin};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vt <= '0;
      for (int unsigned l = 0; l < L; l++)
        for (int unsigned i = 0; i < NP/2; i++)
          st[l][i] <= '0;
    end else begin
      vt <= clr ? '0 : vc[L-1:0];
      for (int unsigned l = 0; l < L; l++)
        for (int unsigned i = 0; i < NP/2; i++)
          st[l][i] <= src[l][2*i] + src[l][2*i+1];
    end
  end

  assign vout = vc[L];
  assign sum  = st[L-1][0];

endmodule

// File: rtl/fir_sym_param.sv
// Symmetric-pair FIR: delay line, pre-add, multiply, adder tree, saturate (LAT = 4 + clog2(TAPS/2)).
// FIR_COEF_LOAD_EN adds a shadow coefficient bank with runtime load and one-cycle swap.
module fir_sym_param
  import fir_pkg::*;
#(
  parameter int DW        = 8,
  parameter int CW        = 8,
  parameter int TAPS      = 16,
  parameter int OW        = 20,
  parameter int IN_SIGNED = 0
) (
  input  logic                       clk,
  input  logic                       rstn,
  fir_sym_param_if.slave             bus
`ifdef FIR_COEF_LOAD_EN
  ,
  input  logic                       coef_we,
  input  logic [clog2(TAPS/2)-1:0]   coef_addr,
  input  logic [CW-1:0]              coef_wdata,
  input  logic                       coef_swap
`endif
);
  localparam int N  = TAPS / 2;
  localparam int L  = clog2(N);
  localparam int XW = DW + 2;
  localparam int PW = DW + CW + 2;
  localparam int SW = PW + L;
  localparam logic signed [OW-1:0] YMAX = OW'(sat_max(OW));
  localparam logic signed [OW-1:0] YMIN = ~YMAX;

  logic [DW-1:0]        dl   [TAPS];
  logic signed [XW-1:0] pr   [N];
  logic signed [PW-1:0] prod [N];
  logic signed [CW-1:0] ceff [N];
  logic                 v0, v1, v2, vt;
  logic signed [SW-1:0] tsum;
  logic [1:0]           rng;

  function automatic logic signed [XW-1:0] ext(input logic [DW-1:0] x);
    if (IN_SIGNED != 0) return XW'(signed'(x));
    else                return XW'(x);
  endfunction

`ifdef FIR_COEF_LOAD_EN
  logic signed [CW-1:0] act [N];
  logic signed [CW-1:0] shd [N];

  // Swap reads the pre-write shadow, so a coincident write lands only in the shadow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < N; i++) begin
        act[i] <= CW'(coef_default(i));
        shd[i] <= CW'(coef_default(i));
      end
    end else begin
      if (coef_swap)
        for (int unsigned i = 0; i < N; i++) act[i] <= shd[i];
      if (coef_we && int'(coef_addr) < N)
        shd[coef_addr] <= coef_wdata;
    end
  end

  always_comb
    for (int unsigned i = 0; i < N; i++) ceff[i] = coef_swap ? shd[i] : act[i];
`else
  always_comb
    for (int unsigned i = 0; i < N; i++) ceff[i] = CW'(coef_default(i));
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < TAPS; i++) dl[i] <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        pr[i]   <= '0;
        prod[i] <= '0;
      end
      v0 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v0 <= bus.en & ~bus.clr;
      v1 <= v0 & ~bus.clr;
      v2 <= v1 & ~bus.clr;
      if (bus.clr) begin
        for (int unsigned i = 0; i < TAPS; i++) dl[i] <= '0;
      end else if (bus.en) begin
        dl[0] <= bus.xin;
        for (int unsigned i = 1; i < TAPS; i++) dl[i] <= dl[i-1];
      end
      for (int unsigned i = 0; i < N; i++) begin
        pr[i]   <= ext(dl[i]) + ext(dl[TAPS-1-i]);
        prod[i] <= PW'(pr[i]) * PW'(ceff[i]);
      end
    end
  end

  fir_add_tree #(.N(N), .W(PW)) u_tree (
    .clk  (clk),
    .rstn (rstn),
    .clr  (bus.clr),
    .vin  (v2),
    .leaf (prod),
    .vout (vt),
    .sum  (tsum)
  );

  assign rng = sat_chk(64'(tsum), OW);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.valid <= 1'b0;
      bus.yout  <= '0;
      bus.sat   <= 1'b0;
    end else begin
      bus.valid <= vt & ~bus.clr;
      if (vt && !bus.clr) begin
        bus.yout <= rng[1] ? YMAX : (rng[0] ? YMIN : OW'(tsum));
        bus.sat  <= |rng;
      end
    end
  end

endmodule

// File: tb/tb_fir_sym_param.sv
// Scoreboard bench: three FIR instances (signed/20b, unsigned/20b, unsigned/12b) against a direct-form model.
module tb_fir_sym_param;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  fir_sym_param_if #(.DW(8), .OW(20)) b0 ();
  fir_sym_param_if #(.DW(8), .OW(20)) b1 ();
  fir_sym_param_if #(.DW(8), .OW(12)) b2 ();

`ifdef FIR_COEF_LOAD_EN
  logic       coef_we    = 1'b0;
  logic       coef_swap  = 1'b0;
  logic [2:0] coef_addr  = '0;
  logic [7:0] coef_wdata = '0;
`endif

  fir_sym_param #(.DW(8), .CW(8), .TAPS(16), .OW(20), .IN_SIGNED(1)) u0 (
    .clk(clk), .rstn(rstn), .bus(b0)
`ifdef FIR_COEF_LOAD_EN
    , .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_swap(coef_swap)
`endif
  );
  fir_sym_param #(.DW(8), .CW(8), .TAPS(16), .OW(20), .IN_SIGNED(0)) u1 (
    .clk(clk), .rstn(rstn), .bus(b1)
`ifdef FIR_COEF_LOAD_EN
    , .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_swap(coef_swap)
`endif
  );
  fir_sym_param #(.DW(8), .CW(8), .TAPS(16), .OW(12), .IN_SIGNED(0)) u2 (
    .clk(clk), .rstn(rstn), .bus(b2)
`ifdef FIR_COEF_LOAD_EN
    , .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .coef_swap(coef_swap)
`endif
  );

  logic   vv [3];
  longint yy [3];
  logic   ss [3];
  assign vv[0] = b0.valid;  assign yy[0] = longint'(b0.yout);  assign ss[0] = b0.sat;
  assign vv[1] = b1.valid;  assign yy[1] = longint'(b1.yout);  assign ss[1] = b1.sat;
  assign vv[2] = b2.valid;  assign yy[2] = longint'(b2.yout);  assign ss[2] = b2.sat;

  typedef struct {
    longint y;
    bit     s;
    int     stamp;
  } exp_t;

  exp_t   q     [3][$];
  int     hist  [3][16];
  int     h     [16];
  int     act_m [8];
  int     shd_m [8];
  int     dflt  [8] = '{-1, -2, -3, -1, 4, 13, 23, 30};
  longint lasty [3];
  bit     lasts [3];

  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int ow_of(input int d);
    return (d == 2) ? 12 : 20;
  endfunction

  task automatic set_h();
    for (int k = 0; k < 8; k++) begin
      h[k]      = act_m[k];
      h[15 - k] = act_m[k];
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      q[d].delete();
      for (int k = 0; k < 16; k++) hist[d][k] = 0;
      lasty[d] = 0;
      lasts[d] = 1'b0;
    end
    act_m = dflt;
    shd_m = dflt;
    set_h();
  endtask

  // Results already in the output register this cycle survive a clr; later ones are dropped.
  task automatic model_flush();
    for (int d = 0; d < 3; d++) begin
      while (q[d].size() > 0 && q[d][$].stamp + 7 > cyc) void'(q[d].pop_back());
      for (int k = 0; k < 16; k++) hist[d][k] = 0;
    end
  endtask

  task automatic model_push(input int x);
    for (int d = 0; d < 3; d++) begin
      int     xi;
      longint acc, lim;
      exp_t   e;
      xi = (d == 0 && x >= 128) ? x - 256 : x;
      for (int k = 15; k > 0; k--) hist[d][k] = hist[d][k-1];
      hist[d][0] = xi;
      acc = 0;
      for (int k = 0; k < 16; k++) acc += longint'(h[k]) * longint'(hist[d][k]);
      lim = (longint'(1) << (ow_of(d) - 1)) - 1;
      e.s = 1'b1;
      if (acc > lim)           e.y = lim;
      else if (acc < -lim - 1) e.y = -lim - 1;
      else begin
        e.y = acc;
        e.s = 1'b0;
      end
      e.stamp = cyc;
      q[d].push_back(e);
    end
  endtask

  task automatic set_in(input bit e, input int x, input bit c);
    b0.en = e;  b0.xin = 8'(x);  b0.clr = c;
    b1.en = e;  b1.xin = 8'(x);  b1.clr = c;
    b2.en = e;  b2.xin = 8'(x);  b2.clr = c;
  endtask

  task automatic drive(input bit e, input int x, input bit c);
    @(posedge clk);
    #1;
    set_in(e, x, c);
    if (c)      model_flush();
    else if (e) model_push(x);
  endtask

  task automatic mon(input int d);
    exp_t  e;
    string u;
    u = $sformatf("u%0d_", d);
    if (!rstn) begin
      chk({u, "rst_valid"}, vv[d], 0);
      chk({u, "rst_yout"},  yy[d], 0);
      chk({u, "rst_sat"},   ss[d], 0);
    end else if (vv[d]) begin
      if (q[d].size() == 0) begin
        chk({u, "unexpected_valid"}, vv[d], 0);
      end else begin
        e = q[d].pop_front();
        chk({u, "yout"},    yy[d], e.y);
        chk({u, "sat"},     ss[d], e.s);
        chk({u, "latency"}, cyc - e.stamp, 7);
        lasty[d] = e.y;
        lasts[d] = e.s;
      end
    end else begin
      chk({u, "hold_yout"}, yy[d], lasty[d]);
      chk({u, "hold_sat"},  ss[d], lasts[d]);
    end
  endtask

  always @(negedge clk)
    for (int d = 0; d < 3; d++) mon(d);

`ifdef FIR_COEF_LOAD_EN
  task automatic coef_op(input bit we, input int a, input int wd, input bit sw);
    @(posedge clk);
    #1;
    coef_we    = we;
    coef_addr  = 3'(a);
    coef_wdata = 8'(wd);
    coef_swap  = sw;
    if (sw) begin
      act_m = shd_m;
      set_h();
    end
    if (we) shd_m[a] = wd;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit [4:0] pat;
    pat = 5'b01101;
    set_in(1'b0, 0, 1'b0);
    model_reset();
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    // impulse: u0 sees +1, unsigned instances see 1 as well
    drive(1'b1, 1, 1'b0);
    repeat (20) drive(1'b1, 0, 1'b0);

    // ramp with en pattern 1,0,1,1,0
    for (int n = 0; n < 20; n++) drive(pat[n % 5], n + 1, 1'b0);

    // held full-scale input: steady state
    repeat (26) drive(1'b1, 255, 1'b0);
    @(negedge clk);
    chk("steady_u1_yout", yy[1], 32130);
    chk("steady_u1_sat",  ss[1], 0);
    chk("steady_u2_yout", yy[2], 2047);
    chk("steady_u2_sat",  ss[2], 1);
    chk("steady_u0_yout", yy[0], -126);

    // random stream with two flushes, the first coinciding with en
    for (int n = 0; n < 40; n++)
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), (n == 15) || (n == 31));

    // reset asserted mid-stream
    repeat (5) drive(1'b1, int'($urandom_range(0, 255)), 1'b0);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    set_in(1'b0, 0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    for (int n = 0; n < 12; n++) drive(1'b1, 3 * n + 7, 1'b0);

`ifdef FIR_COEF_LOAD_EN
    repeat (10) drive(1'b0, 0, 1'b0);
    for (int a = 0; a < 7; a++) coef_op(1'b1, a, 0, 1'b0);
    coef_op(1'b1, 7, 1, 1'b1);
    coef_op(1'b0, 0, 0, 1'b0);
    for (int n = 0; n < 20; n++) drive(1'b1, (5 * n) & 255, 1'b0);
    repeat (10) drive(1'b0, 0, 1'b0);
    coef_op(1'b0, 0, 0, 1'b1);
    coef_op(1'b0, 0, 0, 1'b0);
    for (int n = 0; n < 24; n++) drive(1'b1, (9 * n + 3) & 255, 1'b0);
`endif

    repeat (12) drive(1'b0, 0, 1'b0);
    for (int d = 0; d < 3; d++) chk($sformatf("u%0d_drain", d), q[d].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_sym_param.md
FIR_SYM_PARAM -- requirements
Module: fir_sym_param

Interface
REQ-001 SHALL have parameter DW, default 8: input sample width.
REQ-002 SHALL have parameter CW, default 8: signed coefficient width.
REQ-003 SHALL have parameter TAPS, default 16: filter length; even, range 4..64.
REQ-004 SHALL have parameter OW, default 20: output width.
REQ-005 SHALL have parameter IN_SIGNED, default 0: 0 = unsigned xin, zero-extended; 1 = two's complement.
REQ-006 SHALL have port clk, input, 1 bit: single clock; the sample clock.
REQ-007 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port en, input, 1 bit: xin valid this cycle.
REQ-009 SHALL have port xin, input, DW bits: input sample.
REQ-010 SHALL have port clr, input, 1 bit: synchronous flush.
REQ-011 SHALL have port valid, output, 1 bit: yout valid pulse.
REQ-012 SHALL have port yout, output, OW bits: signed filtered sample.
REQ-013 SHALL have port sat, output, 1 bit: this yout was saturated.
REQ-014 SHALL have ports coef_we (in, 1), coef_addr (in, clog2(TAPS/2)), coef_wdata (in, CW) and coef_swap (in, 1) when FIR_COEF_LOAD_EN is defined.

Function
REQ-015 SHALL shift xin into a TAPS-deep delay line only on cycles with en=1.
REQ-016 SHALL pre-add symmetric pairs x[i]+x[TAPS-1-i], i=0..TAPS/2-1, at DW+2 signed bits.
REQ-017 SHALL multiply each pair by coefficient c[i] to give a DW+CW+2-bit signed product.
REQ-018 SHALL sum the products in a registered binary adder tree, one stage per level (clog2(TAPS/2) stages), at full precision with no intermediate truncation.
REQ-019 SHALL saturate the full-precision sum to OW signed bits; on clipping, sat=1 alongside the clipped yout.
REQ-020 SHALL have latency LAT = 4 + clog2(TAPS/2) cycles from the en cycle to the valid cycle (LAT=7 at default parameters).
REQ-021 SHALL assert valid for exactly one cycle per accepted sample; the pipeline free-runs with a valid tag per stage; en gaps produce valid gaps of equal length.
REQ-022 SHALL hold yout and sat at their last values while valid=0.
REQ-023 SHALL, on clr=1, zero the delay line, clear all stage valid tags and drop in-flight results; an en in the same cycle as clr is ignored; valid=0 for the next LAT cycles.
REQ-024 SHALL write coef_wdata into shadow bank entry coef_addr on coef_we=1.
REQ-025 SHALL copy the whole shadow bank into the active bank on coef_swap=1, in one cycle.
REQ-026 SHALL use the active bank only at the multiply stage; samples reaching that stage in the swap cycle or later use the new bank.
REQ-027 SHALL, when coef_we and coef_swap coincide, copy the pre-write shadow value into the active bank, then write the shadow.

Reset
REQ-028 SHALL, on rstn=0, clear the delay line, all pipeline registers, valid, yout and sat to 0 asynchronously.
REQ-029 SHALL, on rstn=0, load both coefficient banks with the package default table.
REQ-030 SHALL produce no valid pulse from data in flight when reset is asserted mid-stream.

Configuration
REQ-031 SHALL compile the runtime coefficient load port, shadow bank and swap logic in when FIR_COEF_LOAD_EN is defined.
REQ-032 SHALL, without FIR_COEF_LOAD_EN, omit the coef_* ports and use the package default table as constants, with identical latency and arithmetic.

Structure
REQ-033 SHALL place the default coefficient table in shared package fir_pkg, as a function returning c[i]: 16-tap lowpass half {-1,-2,-3,-1,4,13,23,30}.
REQ-034 SHALL place the clog2 helper and the saturation function in fir_pkg.
REQ-035 SHALL implement the adder tree as a single sub-module, fir_add_tree, parametrised by leaf count and width.

Verification
REQ-036 SHALL cover: IN_SIGNED=1, impulse xin=1 then zeros -> yout = -1,-2,-3,-1,4,13,23,30,30,23,13,4,-1,-3,-2,-1, first value 7 cycles after the en cycle.
REQ-037 SHALL cover: unsigned xin=255 held with en=1 -> steady yout=32130, sat=0.
REQ-038 SHALL cover: OW=12, same stimulus -> yout=2047, sat=1.
REQ-039 SHALL cover: FIR_COEF_LOAD_EN, write c0..c6=0, c7=1, swap, ramp input -> yout = x[n-7]+x[n-8].
REQ-040 SHALL cover: en toggling 1,0,1,1,0 -> valid = 1,0,1,1,0 delayed 7 cycles, with results equal to the gapless stream.
REQ-041 SHALL cover: clr, then rstn pulsed mid-stream -> valid=0 for 7 cycles, yout=0 after reset, no stale outputs.
